sha3_block_builder: RTL

SHA3_BLOCK_BUILDER -- requirements
Module: sha3_block_builder

---
 rtl/sha3_pkg.sv | 17 +
 rtl/sha3_block_builder.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/sha3_pkg.sv
// Shared constants and state encoding for the SHA3 rate-block builder.
// The Keccak/SHA3 domain pad choice is made in the builder via KECCAK_LEGACY_PAD_EN.
package sha3_pkg;

    localparam int RATE_BYTES_256 = 136;

    localparam logic [7:0] SHA3_DS   = 8'h06;
    localparam logic [7:0] KECCAK_DS = 8'h01;
    localparam logic [7:0] PAD_END   = 8'h80;

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        PADBLK = 2'd1,
        HOLD   = 2'd2
    } state_t;

endpackage

// File: rtl/sha3_block_builder.sv
// Packs a byte stream into SHA3 rate blocks and applies pad10*1 with the domain byte.
// Define KECCAK_LEGACY_PAD_EN to use the original Keccak domain byte (0x01) instead of 0x06.
module sha3_block_builder
    import sha3_pkg::*;
#(
    parameter int RATE_BYTES = RATE_BYTES_256
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [7:0]              s_data,
    input  logic                    s_last,
    input  logic                    s_empty,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [8*RATE_BYTES-1:0] m_block,
    output logic                    m_last
);

    localparam logic [7:0] LAST_IDX = 8'(RATE_BYTES - 1);

`ifdef KECCAK_LEGACY_PAD_EN
    localparam logic [7:0] DOMAIN_PAD = KECCAK_DS;
`else
    localparam logic [7:0] DOMAIN_PAD = SHA3_DS;
`endif

    state_t                  state;
    state_t                  state_d;
    logic [7:0]              idx;
    logic [7:0]              idx_d;
    logic [7:0]              pad_idx;
    logic                    pending;
    logic                    pending_d;
    logic                    m_last_q;
    logic                    m_last_d;
    logic [8*RATE_BYTES-1:0] buffer;
    logic [8*RATE_BYTES-1:0] buffer_d;
    logic                    s_hs;
    logic                    m_hs;
    logic                    do_write;
    logic                    block_full;

    assign s_hs       = s_valid && (state == FILL);
    assign m_hs       = m_ready && (state == HOLD);
    assign do_write   = s_hs && !(s_last && s_empty);
    assign block_full = do_write && (idx == LAST_IDX);
    // Domain byte lands just past the final data byte (or at idx for an empty beat).
    assign pad_idx    = do_write ? (idx + 8'd1) : idx;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= FILL;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            FILL: begin
                if (s_hs && (s_last || (idx == LAST_IDX))) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (m_hs) begin
                    state_d = pending ? PADBLK : FILL;
                end
            end
            PADBLK: begin
                state_d = HOLD;
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    always_comb begin
        s_ready = (state == FILL);
        m_valid = (state == HOLD);
        m_block = buffer;
        m_last  = m_last_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            buffer   <= '0;
            idx      <= '0;
            pending  <= 1'b0;
            m_last_q <= 1'b0;
        end else begin
            buffer   <= buffer_d;
            idx      <= idx_d;
            pending  <= pending_d;
            m_last_q <= m_last_d;
        end
    end

    // When the pad byte and the end marker hit the same byte they merge into DS|0x80.
    always_comb begin
        buffer_d  = buffer;
        idx_d     = idx;
        pending_d = pending;
        m_last_d  = m_last_q;
        case (state)
            FILL: begin
                if (do_write) begin
                    for (int i = 0; i < RATE_BYTES; i++) begin
                        if (idx == 8'(i)) begin
                            buffer_d[8*i +: 8] = s_data;
                        end
                    end
                    idx_d = idx + 8'd1;
                end
                if (s_hs) begin
                    if (s_last && block_full) begin
                        pending_d = 1'b1;
                        m_last_d  = 1'b0;
                    end else if (s_last) begin
                        for (int i = 0; i < RATE_BYTES; i++) begin
                            if (pad_idx == 8'(i)) begin
                                buffer_d[8*i +: 8] = buffer_d[8*i +: 8] ^ DOMAIN_PAD;
                            end
                        end
                        buffer_d[8*(RATE_BYTES-1) +: 8] = buffer_d[8*(RATE_BYTES-1) +: 8] | PAD_END;
                        m_last_d = 1'b1;
                    end else begin
                        m_last_d = 1'b0;
                    end
                end
            end
            HOLD: begin
                if (m_hs) begin
                    buffer_d  = '0;
                    idx_d     = '0;
                    pending_d = 1'b0;
                end
            end
            PADBLK: begin
                buffer_d = '0;
                buffer_d[7:0] = DOMAIN_PAD;
                buffer_d[8*(RATE_BYTES-1) +: 8] = buffer_d[8*(RATE_BYTES-1) +: 8] | PAD_END;
                m_last_d = 1'b1;
            end
            default: begin
                buffer_d = '0;
                idx_d    = '0;
            end
        endcase
    end

endmodule
